// File: rtl/aig_tt_sweeper_if.sv
// Sweeper <-> requester/function-unit signal bundle.
// exp_tt/match exist only when AIG_TT_SWEEPER_CHECK_EN is defined.
interface aig_tt_sweeper_if;
    logic        start;
    logic        abort;
    logic [3:0]  x;
    logic        y_in;
    logic        busy;
    logic        done;
    logic [15:0] tt_out;
`ifdef AIG_TT_SWEEPER_CHECK_EN
    logic [15:0] exp_tt;
    logic        match;

    modport master (
        input  start, abort, y_in, exp_tt,
        output x, busy, done, tt_out, match
    );
    modport slave (
        output start, abort, y_in, exp_tt,
        input  x, busy, done, tt_out, match
    );
`else
    modport master (
        input  start, abort, y_in,
        output x, busy, done, tt_out
    );
    modport slave (
        output start, abort, y_in,
        input  x, busy, done, tt_out
    );
`endif
endinterface

// File: rtl/aig_tt_sweeper.sv
// Sweeps all 16 vectors into a 4-input function unit, captures a truth table.
// Optional expected-table compare enabled by AIG_TT_SWEEPER_CHECK_EN.
module aig_tt_sweeper #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    aig_tt_sweeper_if.master bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    // Sampling happens on the final SETTLE edge, so SAMPLE is folded in.
    typedef enum logic {IDLE, SETTLE} state_t;

    state_t      state, state_n;
    logic [3:0]  x_q, x_n;
    logic [3:0]  idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0] shadow, shadow_n;
    logic [15:0] tt_q, tt_n;
    logic        done_q, done_n;
`ifdef AIG_TT_SWEEPER_CHECK_EN
    logic [15:0] exp_q, exp_n;
    logic        match_q, match_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_q    <= '0;
            idx    <= '0;
            cnt    <= '0;
            shadow <= '0;
            tt_q   <= '0;
            done_q <= 1'b0;
`ifdef AIG_TT_SWEEPER_CHECK_EN
            exp_q   <= '0;
            match_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            x_q    <= x_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            tt_q   <= tt_n;
            done_q <= done_n;
`ifdef AIG_TT_SWEEPER_CHECK_EN
            exp_q   <= exp_n;
            match_q <= match_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x_q;
        idx_n    = idx;
        cnt_n    = cnt;
        shadow_n = shadow;
        tt_n     = tt_q;
        done_n   = 1'b0;
`ifdef AIG_TT_SWEEPER_CHECK_EN
        exp_n   = exp_q;
        match_n = match_q;
`endif
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_n  = SETTLE;
                    x_n      = '0;
                    idx_n    = '0;
                    cnt_n    = '0;
                    shadow_n = '0;
`ifdef AIG_TT_SWEEPER_CHECK_EN
                    exp_n = bus.exp_tt;
`endif
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    x_n     = '0;
                end else if (cnt == LAST) begin
                    shadow_n[idx] = bus.y_in;
                    if (idx == 4'hF) begin
                        state_n = IDLE;
                        tt_n    = shadow_n;
                        done_n  = 1'b1;
`ifdef AIG_TT_SWEEPER_CHECK_EN
                        match_n = (shadow_n == exp_q);
`endif
                    end else begin
                        idx_n = idx + 4'd1;
                        x_n   = idx + 4'd1;
                        cnt_n = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.x      = x_q;
    assign bus.busy   = (state == SETTLE);
    assign bus.done   = done_q;
    assign bus.tt_out = tt_q;
`ifdef AIG_TT_SWEEPER_CHECK_EN
    assign bus.match  = match_q;
`endif

endmodule

// File: tb/tb_aig_tt_sweeper.sv
// Scoreboard bench: S=1 and S=3 sweepers against a 0x0691 function model.
// Compare checks run when AIG_TT_SWEEPER_CHECK_EN is defined.
module tb_aig_tt_sweeper;

    logic clk = 1'b0;
    logic rst_n;
    logic mode1;
    logic y3;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n;

    logic [15:0] q1[$];
    logic [15:0] q3[$];

    always #5 clk = ~clk;

    aig_tt_sweeper_if sw1 ();
    aig_tt_sweeper_if sw3 ();

    aig_tt_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(sw1)
    );
    aig_tt_sweeper #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(sw3)
    );

    function automatic logic fmodel(input logic [3:0] v);
        logic a;
        a = v[0] ^ v[1];
        return (a & ~v[2] & v[3]) | (~a & ~v[3] & ~(v[1] & ~v[2]));
    endfunction

    assign sw1.y_in = mode1 ? 1'b1 : fmodel(sw1.x);

    // S=3 unit sees one extra register of delay.
    always @(posedge clk) y3 <= fmodel(sw3.x);
    assign sw3.y_in = y3;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (sw1.start && !sw1.abort && !sw1.busy)
                q1.push_back(mode1 ? 16'hFFFF : 16'h0691);
            if (sw1.abort && sw1.busy && q1.size() > 0)
                void'(q1.pop_back());
            if (sw3.start && !sw3.abort && !sw3.busy)
                q3.push_back(16'h0691);
        end
    end

    always @(negedge clk) begin
        if (rst_n && sw1.done) begin
            if (q1.size() == 0) check("done1_unexp", 1, 0);
            else check("tt1", 32'(sw1.tt_out), 32'(q1.pop_front()));
        end
        if (rst_n && sw3.done) begin
            if (q3.size() == 0) check("done3_unexp", 1, 0);
            else check("tt3", 32'(sw3.tt_out), 32'(q3.pop_front()));
        end
    end

    task automatic wait_x1(input logic [3:0] v, input int lim);
        int k = 0;
        while (sw1.x != v && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("wait_x", 32'(sw1.x), 32'(v));
    endtask

    task automatic wait_done1(input int lim, output int cyc);
        cyc = 0;
        while (!sw1.done && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(sw1.done), 1);
    endtask

    task automatic go1();
        sw1.start = 1'b1;
        @(negedge clk);
        sw1.start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        mode1 = 1'b0;
        sw1.start = 1'b0;
        sw1.abort = 1'b0;
        sw3.start = 1'b0;
        sw3.abort = 1'b0;
`ifdef AIG_TT_SWEEPER_CHECK_EN
        sw1.exp_tt = 16'h0691;
        sw3.exp_tt = 16'h0000;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(sw1.busy), 0);
        check("rst_done", 32'(sw1.done), 0);
        check("rst_x", 32'(sw1.x), 0);
        check("rst_tt", 32'(sw1.tt_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // asynchronous reset in the middle of a sweep
        go1();
        wait_x1(4'd7, 40);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(sw1.busy), 0);
        check("arst_done", 32'(sw1.done), 0);
        check("arst_x", 32'(sw1.x), 0);
        check("arst_tt", 32'(sw1.tt_out), 0);
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // S=1 sweep, one vector per cycle
        go1();
        check("busy_run", 32'(sw1.busy), 1);
        for (int k = 0; k < 16; k++) begin
            check("x_step", 32'(sw1.x), 32'(k));
            @(negedge clk);
        end
        check("done_s1", 32'(sw1.done), 1);
        check("busy_end", 32'(sw1.busy), 0);
        check("x_hold", 32'(sw1.x), 32'hF);
        @(negedge clk);
        check("done_pulse", 32'(sw1.done), 0);

        // S=3 sweep with a delayed function unit
        sw3.start = 1'b1;
        @(negedge clk);
        sw3.start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            check("x3_hold", 32'(sw3.x), 32'(k / 3));
            check("done3_early", 32'(sw3.done), 0);
            @(negedge clk);
        end
        check("done_s3", 32'(sw3.done), 1);
        @(negedge clk);

        // abort at idx 9 keeps the previous table
        go1();
        wait_x1(4'd9, 40);
        sw1.abort = 1'b1;
        @(negedge clk);
        sw1.abort = 1'b0;
        check("abort_busy", 32'(sw1.busy), 0);
        check("abort_x", 32'(sw1.x), 0);
        check("abort_done", 32'(sw1.done), 0);
        repeat (20) @(negedge clk);
        check("abort_tt", 32'(sw1.tt_out), 32'h0691);

        // start with abort in IDLE is ignored
        sw1.start = 1'b1;
        sw1.abort = 1'b1;
        @(negedge clk);
        sw1.start = 1'b0;
        sw1.abort = 1'b0;
        check("idle_abort", 32'(sw1.busy), 0);

        go1();
        wait_done1(40, n);
        check("restart_lat", 32'(n), 16);
        @(negedge clk);

        // start held high: back-to-back sweeps every 17 cycles
        mode1 = 1'b1;
        sw1.start = 1'b1;
        wait_done1(40, n);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            wait_done1(40, n);
            check("gap", 32'(n + 1), 17);
        end
        sw1.start = 1'b0;
        @(negedge clk);
        check("held_tt", 32'(sw1.tt_out), 32'hFFFF);
        check("held_idle", 32'(sw1.busy), 0);
        mode1 = 1'b0;
        @(negedge clk);

`ifdef AIG_TT_SWEEPER_CHECK_EN
        sw1.exp_tt = 16'h0691;
        go1();
        wait_done1(40, n);
        check("match_hi", 32'(sw1.match), 1);
        @(negedge clk);
        sw1.exp_tt = 16'h0690;
        go1();
        wait_done1(40, n);
        check("match_lo", 32'(sw1.match), 0);
        @(negedge clk);
        sw1.exp_tt = 16'h0691;
        go1();
        wait_x1(4'd5, 40);
        sw1.abort = 1'b1;
        @(negedge clk);
        sw1.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("match_hold", 32'(sw1.match), 0);
`endif

        repeat (5) @(negedge clk);
        check("q1_empty", 32'(q1.size()), 0);
        check("q3_empty", 32'(q3.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
